// File: rtl/spram_fifo_ctrl_pkg.sv
// Shared defaults, depth helper and RAM-port operation encoding for the
// single-port-RAM FIFO controller.
package spram_fifo_ctrl_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    RAM_IDLE = 2'd0,
    RAM_WR   = 2'd1,
    RAM_RD   = 2'd2
  } ram_op_e;

  function automatic int depth_of(input int addr_width);
    return 32'sd1 << addr_width;
  endfunction

endpackage

// File: rtl/single_port_ram.sv
// Single-port RAM: one shared address, registered read data that only
// updates on non-write cycles.
module single_port_ram #(
  parameter int data_width = 8,
  parameter int addr_width = 4
) (
  input  logic                  clk,
  input  logic                  wr,
  input  logic [addr_width-1:0] addr,
  input  logic [data_width-1:0] din,
  output logic [data_width-1:0] dout
);

  logic [data_width-1:0] mem [2**addr_width];

  // Write on wr, otherwise register the addressed word onto dout
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[addr] <= din;
    end else begin
      dout <= mem[addr];
    end
  end

endmodule

// File: rtl/spram_fifo_ctrl.sv
// Valid/ready FIFO around a single-port RAM: arbitrates the port between
// pushes and prefetch reads, with an output head register and empty bypass.
module spram_fifo_ctrl
  import spram_fifo_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_in_valid,
  input  logic [DATA_WIDTH-1:0] i_in_data,
  output logic                  o_in_ready,
  output logic                  o_out_valid,
  output logic [DATA_WIDTH-1:0] o_out_data,
  input  logic                  i_out_ready,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  localparam int                DEPTH   = depth_of(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] C_DEPTH = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] C_ZERO  = {(ADDR_WIDTH+1){1'b0}};

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_ram_count;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_rd_pending;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;

  logic                  w_pop;
  logic                  w_slot_free;
  logic                  w_read_issue;
  logic                  w_in_ready;
  logic                  w_push;
  logic                  w_bypass;
  logic                  w_ram_wr;
  logic [ADDR_WIDTH-1:0] w_ram_addr;
  logic [DATA_WIDTH-1:0] w_ram_dout;
  ram_op_e               w_ram_op;

  assign w_pop        = r_out_valid & i_out_ready;
  assign w_slot_free  = ~r_out_valid | w_pop;
  assign w_read_issue = (r_ram_count != C_ZERO) & ~r_rd_pending & w_slot_free;
  assign w_in_ready   = ~w_read_issue & (r_ram_count != C_DEPTH);
  assign w_push       = i_in_valid & w_in_ready;
  // Bypass only when nothing older sits in the RAM or in flight
  assign w_bypass     = w_push & (r_ram_count == C_ZERO) & ~r_rd_pending & w_slot_free;

  // Port arbitration: reads win over writes
  always_comb begin
    w_ram_op = RAM_IDLE;
    if (w_read_issue) begin
      w_ram_op = RAM_RD;
    end else if (w_push && !w_bypass) begin
      w_ram_op = RAM_WR;
    end else begin
      w_ram_op = RAM_IDLE;
    end
  end

  assign w_ram_wr   = (w_ram_op == RAM_WR);
  assign w_ram_addr = w_ram_wr ? r_wr_ptr : r_rd_ptr;

  single_port_ram #(
    .data_width (DATA_WIDTH),
    .addr_width (ADDR_WIDTH)
  ) u_ram (
    .clk  (i_clk),
    .wr   (w_ram_wr),
    .addr (w_ram_addr),
    .din  (i_in_data),
    .dout (w_ram_dout)
  );

  // Pointers, occupancy and read-in-flight tracking
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr     <= {ADDR_WIDTH{1'b0}};
      r_rd_ptr     <= {ADDR_WIDTH{1'b0}};
      r_ram_count  <= C_ZERO;
      r_count      <= C_ZERO;
      r_rd_pending <= 1'b0;
    end else begin
      r_rd_pending <= w_read_issue;
      if (w_read_issue) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_ram_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      case ({w_read_issue, w_ram_wr})
        2'b10:   r_ram_count <= r_ram_count - 1'b1;
        2'b01:   r_ram_count <= r_ram_count + 1'b1;
        default: r_ram_count <= r_ram_count;
      endcase
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Head register: RAM read result, bypassed input, or drained by a pop
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= {DATA_WIDTH{1'b0}};
    end else if (r_rd_pending) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_ram_dout;
    end else if (w_bypass) begin
      r_out_valid <= 1'b1;
      r_out_data  <= i_in_data;
    end else if (w_pop) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  assign o_in_ready  = w_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out_data  = r_out_data;
  assign o_count     = r_count;
  assign o_full      = (r_ram_count == C_DEPTH);
  assign o_empty     = (r_count == C_ZERO);

endmodule
